alu_dsp_core: RTL and testbench
===============================

Name: alu_dsp_core

Overview:
Registered arithmetic primitive that stands in for the iCE40 SB_MAC16 blocks used by the sail-core ALU. It provides three functions:
- 32-bit add, with carry-out.
- 32-bit subtract.
- 16x16 unsigned multiply, used as a power-of-two shifter.

It sits between the ALU operand muxes and the ALU result mux. It replaces the separate adder_dsp, subtractor_dsp and shift_dsp instances with one clocked unit of fixed latency.

Parameters:
- WIDTH, 32, add/sub operand and result width; must be even and at least 2.
- MUL_WIDTH, 16, multiplier operand width; the product is 2*MUL_WIDTH and must equal WIDTH.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  operands and op are sampled this cycle.
- op  input  2  00 ADD, 01 SUB, 10 MUL, 11 reserved.
- input1  input  WIDTH  first add/sub operand.
- input2  input  WIDTH  second add/sub operand.
- mul_a  input  MUL_WIDTH  multiplicand (shift data half-word).
- mul_b  input  MUL_WIDTH  multiplier (one-hot shift amount, 1<<n).
- out  output  WIDTH  registered result.
- carry_out  output  1  registered carry (ADD) or borrow (SUB); 0 for MUL.
- out_valid  output  1  out/carry_out hold the result of a sampled request.

Behaviour:
- Reset: on a rising clk edge with rst_n=0, out=0, carry_out=0 and out_valid=0. Reset has priority over in_valid.
- Reset mid-operation discards the in-flight result; no partial result is ever presented.
- Latency is exactly 1 cycle: request sampled at edge N appears at edge N+1.
  - out_valid(N+1) = in_valid(N).
  - Fully pipelined; a new request is accepted every cycle.
  - No backpressure and no ready signal.
- When in_valid=0, out and carry_out hold their previous values and out_valid=0.
- ADD: {carry_out, out} = input1 + input2, computed at WIDTH+1 bits. out wraps modulo 2^WIDTH.
- SUB: out = (input2 - input1) mod 2^WIDTH. carry_out = 1 when input1 > input2 (unsigned borrow).
  - Operand order is fixed: the ALU wires input1=B and input2=A, so out = A-B.
- MUL: out = mul_a * mul_b, unsigned, full 2*MUL_WIDTH-bit product, carry_out=0.
  - With mul_b = 1<<n (n in 0..15), out = mul_a shifted left by n, zero-filled.
  - mul_b=0 gives out=0.
  - Non-one-hot mul_b is legal and gives the true product.
- op=11: out=0, carry_out=0; out_valid still follows in_valid.
- AND/XOR interleave property (ADD): place a[i] at bit 2i of input1 and b[i] at bit 2i of input2, with all odd bits 0. Then out[2i] = a[i]^b[i] and out[2i+1] = a[i]&b[i]. No extra logic is needed; the bench checks this property.
- Unused operands are don't-care and must not affect the result (e.g. mul_a/mul_b during ADD).
- No X propagation from unused inputs into registered state.

Decomposition:
- Shared package alu_dsp_pkg:
  - op encodings ALU_DSP_OP_ADD=2'b00, ALU_DSP_OP_SUB=2'b01, ALU_DSP_OP_MUL=2'b10.
  - Default widths.
- One sub-module is natural: alu_dsp_addsub, a combinational WIDTH+1-bit add/subtract with carry/borrow. The multiplier and the result register live in the top.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with in_valid=1, op=ADD, input1=input2=0xFFFFFFFF -> out=0x00000000, carry_out=0, out_valid=0. Release, then the next request is honoured.
- ADD basic and wrap:
  - input1=0x5, input2=0x3 -> next cycle out=0x00000008, carry_out=0.
  - input1=0xFFFFFFFF, input2=0x1 -> out=0x00000000, carry_out=1.
- SUB:
  - input1=0x3, input2=0x5 -> out=0x00000002, carry_out=0.
  - input1=0x5, input2=0x3 -> out=0xFFFFFFFE, carry_out=1.
- MUL shift:
  - mul_a=0x8001, mul_b=0x0010 -> out=0x00080010.
  - mul_a=0xFFFF, mul_b=0x8000 -> out=0x7FFF8000.
  - mul_b=0 -> out=0.
- Interleaved AND/XOR: ADD with a=0b11, b=0b01 encoded as input1=0x5, input2=0x1 -> out=0x6, i.e. bit0=xor 0, bit1=and 1, bit2=xor 1, bit3=and 0.
- Pipelining and hold:
  - Back-to-back ADD, SUB, MUL on consecutive cycles -> three consecutive correct results with out_valid=1.
  - Then in_valid=0 -> out holds the MUL result and out_valid=0.
  - Assert rst_n=0 mid-stream -> out clears to 0 at that edge.

Source files
------------

// File: rtl/alu_dsp_pkg.sv
// Purpose: shared op encodings and default widths for the ALU arithmetic primitive.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_dsp_pkg;

  localparam int ALU_DSP_WIDTH     = 32;
  localparam int ALU_DSP_MUL_WIDTH = 16;

  typedef enum logic [1:0] {
    ALU_DSP_OP_ADD  = 2'b00,
    ALU_DSP_OP_SUB  = 2'b01,
    ALU_DSP_OP_MUL  = 2'b10,
    ALU_DSP_OP_RSVD = 2'b11
  } alu_dsp_op_e;

endpackage

// File: rtl/alu_dsp_addsub.sv
// Purpose: combinational WIDTH+1-bit add / subtract with carry or borrow.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
//
// Ports:
//   input1, input2 : operands; subtract computes input2 - input1
//   sub            : 0 = add, 1 = subtract
//   result         : low WIDTH bits of the sum / difference
//   carry          : carry-out on add, unsigned borrow (input1 > input2) on subtract
module alu_dsp_addsub #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  input  logic             sub,
  output logic [WIDTH-1:0] result,
  output logic             carry
);

  logic [WIDTH:0] sum_ext;
  logic [WIDTH:0] diff_ext;

  // Zero-extended to WIDTH+1 bits: the extra bit of the sum is the carry,
  // the extra bit of the difference goes high exactly when input1 > input2.
  assign sum_ext  = {1'b0, input1} + {1'b0, input2};
  assign diff_ext = {1'b0, input2} - {1'b0, input1};

  always_comb begin
    result = sum_ext[WIDTH-1:0];
    carry  = sum_ext[WIDTH];
    if (sub) begin
      result = diff_ext[WIDTH-1:0];
      carry  = diff_ext[WIDTH];
    end
  end

endmodule

// File: rtl/alu_dsp_core.sv
// Purpose: registered add / subtract / 16x16 multiply standing in for the SB_MAC16 ALU helpers.
// Latency: exactly 1 cycle, fully pipelined (one request per cycle).
// Backpressure: none; every in_valid request produces out_valid on the next cycle.
//
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid, op        : request strobe and operation (ADD/SUB/MUL/reserved)
//   input1, input2      : add/sub operands (SUB gives input2 - input1)
//   mul_a, mul_b        : multiplier operands (mul_b one-hot when used as a shifter)
//   out, carry_out      : registered result and carry/borrow, held while idle
//   out_valid           : high for one cycle per accepted request
module alu_dsp_core
  import alu_dsp_pkg::*;
#(
  parameter int WIDTH     = ALU_DSP_WIDTH,
  parameter int MUL_WIDTH = ALU_DSP_MUL_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [1:0]           op,
  input  logic [WIDTH-1:0]     input1,
  input  logic [WIDTH-1:0]     input2,
  input  logic [MUL_WIDTH-1:0] mul_a,
  input  logic [MUL_WIDTH-1:0] mul_b,
  output logic [WIDTH-1:0]     out,
  output logic                 carry_out,
  output logic                 out_valid
);

  logic [WIDTH-1:0] addsub_result;
  logic             addsub_carry;
  logic             is_sub;
  logic [WIDTH-1:0] product;
  logic [WIDTH-1:0] result_next;
  logic             carry_next;

  assign is_sub = (op == ALU_DSP_OP_SUB);

  alu_dsp_addsub #(
    .WIDTH (WIDTH)
  ) u_addsub (
    .input1 (input1),
    .input2 (input2),
    .sub    (is_sub),
    .result (addsub_result),
    .carry  (addsub_carry)
  );

  // Product is 2*MUL_WIDTH bits, which equals WIDTH, so the full product fits.
  // With a one-hot mul_b this is a zero-filling left shift of mul_a.
  assign product = WIDTH'(mul_a) * WIDTH'(mul_b);

  // The op mux selects only the path in use, so unused operands (including
  // X on them) never reach the result register.
  always_comb begin
    result_next = '0;
    carry_next  = 1'b0;
    case (op)
      ALU_DSP_OP_ADD,
      ALU_DSP_OP_SUB: begin
        result_next = addsub_result;
        carry_next  = addsub_carry;
      end
      ALU_DSP_OP_MUL: begin
        result_next = product;
      end
      default: begin
        result_next = '0;
        carry_next  = 1'b0;
      end
    endcase
  end

  // Reset wins over in_valid, so a request in flight at reset is dropped.
  // Result and carry hold while idle; out_valid is a plain one-cycle delay.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out       <= '0;
      carry_out <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out       <= result_next;
        carry_out <= carry_next;
      end
    end
  end

endmodule

// File: tb/tb_alu_dsp_core.sv
// Purpose: directed self-checking bench for alu_dsp_core.
// Latency: checks one-cycle result latency and back-to-back issue.
// Backpressure: n/a (DUT has none).
module tb_alu_dsp_core;
  import alu_dsp_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [1:0]  op;
  logic [31:0] input1;
  logic [31:0] input2;
  logic [15:0] mul_a;
  logic [15:0] mul_b;
  logic [31:0] out;
  logic        carry_out;
  logic        out_valid;

  int compared = 0;
  int failed   = 0;

  alu_dsp_core #(
    .WIDTH     (32),
    .MUL_WIDTH (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .op        (op),
    .input1    (input1),
    .input2    (input2),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .out       (out),
    .carry_out (carry_out),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply inputs, then advance to 1 time unit after the next rising edge.
  task automatic drive_step(input logic v, input logic [1:0] o,
                            input logic [31:0] i1, input logic [31:0] i2,
                            input logic [15:0] ma, input logic [15:0] mb);
    in_valid = v;
    op       = o;
    input1   = i1;
    input2   = i2;
    mul_a    = ma;
    mul_b    = mb;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_step(1'b1, ALU_DSP_OP_ADD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 16'h0, 16'h0);
    drive_step(1'b1, ALU_DSP_OP_ADD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 16'h0, 16'h0);
    compared++;
    if (out !== 32'h0) begin failed++; $display("FAIL reset_out: got %h want %h", out, 32'h0); end
    compared++;
    if (carry_out !== 1'b0) begin failed++; $display("FAIL reset_carry: got %b want 0", carry_out); end
    compared++;
    if (out_valid !== 1'b0) begin failed++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    rst_n = 1'b1;
    drive_step(1'b1, ALU_DSP_OP_ADD, 32'h1, 32'h2, 16'h0, 16'h0);
    compared++;
    if (out !== 32'h3) begin failed++; $display("FAIL post_reset_out: got %h want %h", out, 32'h3); end
    compared++;
    if (out_valid !== 1'b1) begin failed++; $display("FAIL post_reset_valid: got %b want 1", out_valid); end
  endtask

  task automatic test_add();
    // mul operands carry junk: they must not influence an ADD.
    drive_step(1'b1, ALU_DSP_OP_ADD, 32'h5, 32'h3, 16'hDEAD, 16'hBEEF);
    compared++;
    if (out !== 32'h8) begin failed++; $display("FAIL add_basic_out: got %h want %h", out, 32'h8); end
    compared++;
    if (carry_out !== 1'b0) begin failed++; $display("FAIL add_basic_carry: got %b want 0", carry_out); end
    drive_step(1'b1, ALU_DSP_OP_ADD, 32'hFFFF_FFFF, 32'h1, 16'hFFFF, 16'hFFFF);
    compared++;
    if (out !== 32'h0) begin failed++; $display("FAIL add_wrap_out: got %h want %h", out, 32'h0); end
    compared++;
    if (carry_out !== 1'b1) begin failed++; $display("FAIL add_wrap_carry: got %b want 1", carry_out); end
    compared++;
    if (out_valid !== 1'b1) begin failed++; $display("FAIL add_wrap_valid: got %b want 1", out_valid); end
  endtask

  task automatic test_sub();
    drive_step(1'b1, ALU_DSP_OP_SUB, 32'h3, 32'h5, 16'h1234, 16'h5678);
    compared++;
    if (out !== 32'h2) begin failed++; $display("FAIL sub_pos_out: got %h want %h", out, 32'h2); end
    compared++;
    if (carry_out !== 1'b0) begin failed++; $display("FAIL sub_pos_borrow: got %b want 0", carry_out); end
    drive_step(1'b1, ALU_DSP_OP_SUB, 32'h5, 32'h3, 16'h0, 16'h0);
    compared++;
    if (out !== 32'hFFFF_FFFE) begin failed++; $display("FAIL sub_neg_out: got %h want %h", out, 32'hFFFF_FFFE); end
    compared++;
    if (carry_out !== 1'b1) begin failed++; $display("FAIL sub_neg_borrow: got %b want 1", carry_out); end
    // Idle cycle with different operands: result and borrow must hold.
    drive_step(1'b0, ALU_DSP_OP_ADD, 32'h7, 32'h7, 16'h0, 16'h0);
    compared++;
    if (out !== 32'hFFFF_FFFE) begin failed++; $display("FAIL sub_hold_out: got %h want %h", out, 32'hFFFF_FFFE); end
    compared++;
    if (carry_out !== 1'b1) begin failed++; $display("FAIL sub_hold_borrow: got %b want 1", carry_out); end
    compared++;
    if (out_valid !== 1'b0) begin failed++; $display("FAIL sub_hold_valid: got %b want 0", out_valid); end
    // Reserved op clears both out and the previously set borrow.
    drive_step(1'b1, ALU_DSP_OP_RSVD, 32'h5, 32'h3, 16'hFFFF, 16'h0001);
    compared++;
    if (out !== 32'h0) begin failed++; $display("FAIL rsvd_out: got %h want %h", out, 32'h0); end
    compared++;
    if (carry_out !== 1'b0) begin failed++; $display("FAIL rsvd_carry: got %b want 0", carry_out); end
    compared++;
    if (out_valid !== 1'b1) begin failed++; $display("FAIL rsvd_valid: got %b want 1", out_valid); end
  endtask

  task automatic test_mul();
    // Prime carry_out high so MUL visibly clears it.
    drive_step(1'b1, ALU_DSP_OP_ADD, 32'hFFFF_FFFF, 32'h1, 16'h0, 16'h0);
    drive_step(1'b1, ALU_DSP_OP_MUL, 32'hFFFF_FFFF, 32'h1, 16'h8001, 16'h0010);
    compared++;
    if (out !== 32'h0008_0010) begin failed++; $display("FAIL mul_shift4_out: got %h want %h", out, 32'h0008_0010); end
    compared++;
    if (carry_out !== 1'b0) begin failed++; $display("FAIL mul_carry: got %b want 0", carry_out); end
    drive_step(1'b1, ALU_DSP_OP_MUL, 32'h0, 32'h0, 16'hFFFF, 16'h8000);
    compared++;
    if (out !== 32'h7FFF_8000) begin failed++; $display("FAIL mul_shift15_out: got %h want %h", out, 32'h7FFF_8000); end
    drive_step(1'b1, ALU_DSP_OP_MUL, 32'h0, 32'h0, 16'h1234, 16'h0003);
    compared++;
    if (out !== 32'h0000_369C) begin failed++; $display("FAIL mul_nononehot_out: got %h want %h", out, 32'h0000_369C); end
    drive_step(1'b1, ALU_DSP_OP_MUL, 32'hAAAA_AAAA, 32'h5555_5555, 16'hABCD, 16'h0000);
    compared++;
    if (out !== 32'h0) begin failed++; $display("FAIL mul_zero_out: got %h want %h", out, 32'h0); end
  endtask

  task automatic test_interleave();
    // a=0b11 at even bits of input1, b=0b01 at even bits of input2.
    drive_step(1'b1, ALU_DSP_OP_ADD, 32'h5, 32'h1, 16'h0, 16'h0);
    compared++;
    if (out !== 32'h6) begin failed++; $display("FAIL interleave_small: got %h want %h", out, 32'h6); end
    // a=0xFFFF, b=0x00FF: pairs (1,1) give "10", pairs (1,0) give "01".
    drive_step(1'b1, ALU_DSP_OP_ADD, 32'h5555_5555, 32'h0000_5555, 16'h0, 16'h0);
    compared++;
    if (out !== 32'h5555_AAAA) begin failed++; $display("FAIL interleave_wide: got %h want %h", out, 32'h5555_AAAA); end
  endtask

  task automatic test_back_to_back();
    drive_step(1'b1, ALU_DSP_OP_ADD, 32'h10, 32'h20, 16'h0, 16'h0);
    compared++;
    if (out !== 32'h30 || out_valid !== 1'b1) begin
      failed++; $display("FAIL b2b_add: got %h/%b want %h/1", out, out_valid, 32'h30);
    end
    drive_step(1'b1, ALU_DSP_OP_SUB, 32'h1, 32'h0, 16'h0, 16'h0);
    compared++;
    if (out !== 32'hFFFF_FFFF || carry_out !== 1'b1 || out_valid !== 1'b1) begin
      failed++; $display("FAIL b2b_sub: got %h/%b/%b want %h/1/1", out, carry_out, out_valid, 32'hFFFF_FFFF);
    end
    drive_step(1'b1, ALU_DSP_OP_MUL, 32'h0, 32'h0, 16'h00FF, 16'h0100);
    compared++;
    if (out !== 32'h0000_FF00 || carry_out !== 1'b0 || out_valid !== 1'b1) begin
      failed++; $display("FAIL b2b_mul: got %h/%b/%b want %h/0/1", out, carry_out, out_valid, 32'h0000_FF00);
    end
    drive_step(1'b0, ALU_DSP_OP_ADD, 32'h1, 32'h1, 16'h0, 16'h0);
    compared++;
    if (out !== 32'h0000_FF00 || out_valid !== 1'b0) begin
      failed++; $display("FAIL b2b_hold: got %h/%b want %h/0", out, out_valid, 32'h0000_FF00);
    end
    // Reset mid-stream with a live request: that request must be discarded.
    rst_n = 1'b0;
    drive_step(1'b1, ALU_DSP_OP_ADD, 32'h11, 32'h22, 16'h0, 16'h0);
    compared++;
    if (out !== 32'h0 || carry_out !== 1'b0 || out_valid !== 1'b0) begin
      failed++; $display("FAIL midreset: got %h/%b/%b want 0/0/0", out, carry_out, out_valid);
    end
    rst_n = 1'b1;
    drive_step(1'b0, ALU_DSP_OP_ADD, 32'h11, 32'h22, 16'h0, 16'h0);
    compared++;
    if (out !== 32'h0 || out_valid !== 1'b0) begin
      failed++; $display("FAIL after_reset_idle: got %h/%b want 0/0", out, out_valid);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    op       = ALU_DSP_OP_ADD;
    input1   = '0;
    input2   = '0;
    mul_a    = '0;
    mul_b    = '0;
    test_reset();
    test_add();
    test_sub();
    test_mul();
    test_interleave();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
